// File: rtl/gmii_pkt_pkg.sv
// Shared types and helpers for the GMII packet buffer: word tags, write FSM
// states and output word geometry.
package gmii_pkt_pkg;

  localparam logic [1:0] TAG_MID  = 2'b00;
  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;
  localparam logic [1:0] TAG_SOLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCU    = 2'd1,
    DISCARD = 2'd2
  } wr_state_e;

  function automatic int pkt_vw(input int bpw);
    return $clog2(bpw);
  endfunction

  function automatic int pkt_ow(input int bpw);
    return 2 + $clog2(bpw) + 8 * bpw;
  endfunction

endpackage

// File: rtl/gmii_to_pkt_buf_fifo.sv
// Store-and-forward word FIFO with commit/rollback write pointer and a
// registered valid/ready output stage; the reader only sees committed words.
module pkt_commit_fifo
  import gmii_pkt_pkg::*;
#(
  parameter int OW    = 134,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [OW-1:0]            wr_word_i,
  input  logic                     commit_i,
  input  logic                     rollback_i,
  output logic                     full_o,
  output logic [OW-1:0]            out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   used_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [OW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] cm_ptr_q, cm_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] fe_ptr_q, fe_ptr_d;
  logic [PW-1:0] used_q, used_d;
  logic          cm_pend_q;
  logic [OW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          load_s, accept_s;

  // rd_ptr only advances on acceptance, so a word sitting in the output
  // register still occupies its RAM slot and counts toward full.
  assign full_o      = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign used_o      = used_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_word_i;
    end
  end

  always_comb begin
    accept_s = valid_q && out_ready_i;
    load_s   = (fe_ptr_q != cm_ptr_q) && (!valid_q || out_ready_i);
    if (rollback_i) begin
      wr_ptr_d = cm_ptr_q;
    end else if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    cm_ptr_d = cm_pend_q ? wr_ptr_q : cm_ptr_q;
    rd_ptr_d = accept_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
    fe_ptr_d = load_s ? fe_ptr_q + PW'(1) : fe_ptr_q;
    if (load_s) begin
      data_d  = mem_q[fe_ptr_q[AW-1:0]];
      valid_d = 1'b1;
    end else if (accept_s) begin
      data_d  = data_q;
      valid_d = 1'b0;
    end else begin
      data_d  = data_q;
      valid_d = valid_q;
    end
    used_d = cm_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= PW'(0);
      cm_ptr_q  <= PW'(0);
      rd_ptr_q  <= PW'(0);
      fe_ptr_q  <= PW'(0);
      used_q    <= PW'(0);
      cm_pend_q <= 1'b0;
      data_q    <= OW'(0);
      valid_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cm_ptr_q  <= cm_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fe_ptr_q  <= fe_ptr_d;
      used_q    <= used_d;
      cm_pend_q <= commit_i;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: rtl/gmii_to_pkt_buf.sv
// GMII byte stream to tagged BPW-byte packet words via a commit/rollback FIFO.
// Optional GMII_PKT_ER_DROP_EN adds gmii_er and drops errored frames.
module gmii_to_pkt_buf
  import gmii_pkt_pkg::*;
#(
  parameter int BPW        = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int MIN_BYTES  = 17,
  parameter int MAX_BYTES  = 2096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   gmii_data,
  input  logic                         gmii_dv,
`ifdef GMII_PKT_ER_DROP_EN
  input  logic                         gmii_er,
`endif
  output logic [pkt_ow(BPW)-1:0]       out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  cnt_pkt_in,
  output logic [31:0]                  cnt_pkt_out,
  output logic [31:0]                  cnt_drop,
  output logic [31:0]                  cnt_trunc,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_used
);

  localparam int VW = pkt_vw(BPW);
  localparam int DW = 8 * BPW;
  localparam int OW = pkt_ow(BPW);
  localparam int CW = $clog2(MAX_BYTES + 1);

  wr_state_e     state_q, state_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          head_pend_q, head_pend_d;
  logic [31:0]   pkt_in_q, pkt_out_q, drop_q, trunc_q;

  logic          er_s, full_s, at_max_s, accept_s;
  logic          wr_en_s, commit_s, rollback_s, drop_s, trunc_s;
  logic [1:0]    tag_s;
  logic [VW-1:0] vb_s, lane_s, tail_vb_s;
  logic [DW-1:0] byte_word_s, byte_lane_s;
  logic [OW-1:0] wr_word_s;

`ifdef GMII_PKT_ER_DROP_EN
  assign er_s = gmii_er;
`else
  assign er_s = 1'b0;
`endif

  // A full word stays buffered until the next byte proves it is not the tail.
  assign lane_s      = byte_cnt_q[VW-1:0];
  assign tail_vb_s   = lane_s - VW'(1);
  assign at_max_s    = (byte_cnt_q == CW'(MAX_BYTES));
  assign byte_word_s = {gmii_data, {(DW-8){1'b0}}};
  assign byte_lane_s = byte_word_s >> {lane_s, 3'b000};
  assign wr_word_s   = {tag_s, vb_s, buf_q};
  assign accept_s    = out_valid && out_ready;

  assign cnt_pkt_in  = pkt_in_q;
  assign cnt_pkt_out = pkt_out_q;
  assign cnt_drop    = drop_q;
  assign cnt_trunc   = trunc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gmii_dv) begin
          state_d = er_s ? DISCARD : ACCU;
        end else begin
          state_d = IDLE;
        end
      end
      ACCU: begin
        if (gmii_dv && er_s) begin
          state_d = DISCARD;
        end else if (at_max_s || !gmii_dv) begin
          state_d = gmii_dv ? DISCARD : IDLE;
        end else if (lane_s == VW'(0) && full_s) begin
          state_d = DISCARD;
        end else begin
          state_d = ACCU;
        end
      end
      DISCARD: begin
        state_d = gmii_dv ? DISCARD : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_en_s     = 1'b0;
    commit_s    = 1'b0;
    rollback_s  = 1'b0;
    drop_s      = 1'b0;
    trunc_s     = 1'b0;
    tag_s       = TAG_MID;
    vb_s        = VW'(BPW - 1);
    byte_cnt_d  = byte_cnt_q;
    buf_d       = buf_q;
    head_pend_d = head_pend_q;
    case (state_q)
      IDLE: begin
        if (gmii_dv && er_s) begin
          drop_s = 1'b1;
        end else if (gmii_dv) begin
          buf_d       = byte_word_s;
          byte_cnt_d  = CW'(1);
          head_pend_d = 1'b1;
        end else begin
          buf_d = buf_q;
        end
      end
      ACCU: begin
        if (gmii_dv && er_s) begin
          rollback_s = 1'b1;
          drop_s     = 1'b1;
        end else if (at_max_s || !gmii_dv) begin
          if (byte_cnt_q < CW'(MIN_BYTES) || full_s) begin
            rollback_s = 1'b1;
            drop_s     = 1'b1;
          end else begin
            wr_en_s  = 1'b1;
            commit_s = 1'b1;
            trunc_s  = at_max_s;
            tag_s    = head_pend_q ? TAG_SOLE : TAG_TAIL;
            vb_s     = tail_vb_s;
          end
        end else if (lane_s == VW'(0)) begin
          if (full_s) begin
            rollback_s = 1'b1;
            drop_s     = 1'b1;
          end else begin
            wr_en_s     = 1'b1;
            tag_s       = head_pend_q ? TAG_HEAD : TAG_MID;
            head_pend_d = 1'b0;
            buf_d       = byte_word_s;
            byte_cnt_d  = byte_cnt_q + CW'(1);
          end
        end else begin
          buf_d      = buf_q | byte_lane_s;
          byte_cnt_d = byte_cnt_q + CW'(1);
        end
      end
      DISCARD: begin
        buf_d = buf_q;
      end
      default: begin
        buf_d = buf_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q  <= CW'(0);
      buf_q       <= DW'(0);
      head_pend_q <= 1'b0;
      pkt_in_q    <= 32'd0;
      pkt_out_q   <= 32'd0;
      drop_q      <= 32'd0;
      trunc_q     <= 32'd0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      buf_q       <= buf_d;
      head_pend_q <= head_pend_d;
      pkt_in_q    <= pkt_in_q + 32'(commit_s);
      pkt_out_q   <= pkt_out_q + 32'(accept_s && out_data[OW-1]);
      drop_q      <= drop_q + 32'(drop_s);
      trunc_q     <= trunc_q + 32'(trunc_s);
    end
  end

  pkt_commit_fifo #(
    .OW    (OW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (wr_en_s),
    .wr_word_i   (wr_word_s),
    .commit_i    (commit_s),
    .rollback_i  (rollback_s),
    .full_o      (full_s),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .used_o      (fifo_used)
  );

endmodule

// File: tb/tb_gmii_to_pkt_buf.sv
// Randomised bench for gmii_to_pkt_buf with a frame-level reference model.
module tb_gmii_to_pkt_buf;

  localparam int BPW        = 16;
  localparam int FIFO_DEPTH = 512;
  localparam int MIN_BYTES  = 17;
  localparam int MAX_BYTES  = 2096;
  localparam int VW         = 4;
  localparam int DW         = 8 * BPW;
  localparam int OW         = 2 + VW + DW;
  localparam int PW         = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    gmii_data = 8'h00;
  logic          gmii_dv = 1'b0;
`ifdef GMII_PKT_ER_DROP_EN
  logic          gmii_er = 1'b0;
`endif
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   cnt_pkt_in, cnt_pkt_out, cnt_drop, cnt_trunc;
  logic [PW-1:0] fifo_used;

  gmii_to_pkt_buf #(
    .BPW(BPW), .FIFO_DEPTH(FIFO_DEPTH), .MIN_BYTES(MIN_BYTES), .MAX_BYTES(MAX_BYTES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gmii_data   (gmii_data),
    .gmii_dv     (gmii_dv),
`ifdef GMII_PKT_ER_DROP_EN
    .gmii_er     (gmii_er),
`endif
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .cnt_pkt_in  (cnt_pkt_in),
    .cnt_pkt_out (cnt_pkt_out),
    .cnt_drop    (cnt_drop),
    .cnt_trunc   (cnt_trunc),
    .fifo_used   (fifo_used)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: whole frames in, expected words out.
  logic [7:0]    frm[$];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] rx_log[$];
  int m_pkt_in = 0, m_drop = 0, m_trunc = 0;
  int valid_cycles = 0;
  int ready_mode = 0;
  int cyc = 0;

  task automatic model_frame();
    int len, l, nw;
    logic [OW-1:0] w;
    len = frm.size();
    if (len < MIN_BYTES) begin
      m_drop++;
      return;
    end
    l = (len > MAX_BYTES) ? MAX_BYTES : len;
    if (len >= MAX_BYTES) m_trunc++;
    m_pkt_in++;
    nw = (l + BPW - 1) / BPW;
    for (int i = 0; i < nw; i++) begin
      w = '0;
      w[OW-1] = (i == nw - 1);
      w[OW-2] = (i == 0);
      w[DW +: VW] = (i == nw - 1) ? VW'((l - 1) % BPW) : VW'(BPW - 1);
      for (int k = 0; k < BPW; k++) begin
        if (i * BPW + k < l) w[DW - 1 - 8 * k -: 8] = frm[i * BPW + k];
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic make_seq(input int len);
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'(i % 256));
  endtask

  task automatic make_rand(input int len);
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
  endtask

  task automatic drive_frame(input int gap);
    for (int i = 0; i < frm.size(); i++) begin
      @(posedge clk); #1;
      gmii_dv = 1'b1;
      gmii_data = frm[i];
    end
    @(posedge clk); #1;
    gmii_dv = 1'b0;
    gmii_data = 8'h00;
    for (int g = 1; g < gap; g++) @(posedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    repeat (6) @(posedge clk);
    check_val({tag, "_drain"}, 256'(exp_q.size()), 256'd0);
  endtask

  task automatic check_counters(input string tag);
    @(negedge clk);
    check_val({tag, "_pkt_in"}, 256'(cnt_pkt_in), 256'(m_pkt_in));
    check_val({tag, "_pkt_out"}, 256'(cnt_pkt_out), 256'(m_pkt_in));
    check_val({tag, "_drop"}, 256'(cnt_drop), 256'(m_drop));
    check_val({tag, "_trunc"}, 256'(cnt_trunc), 256'(m_trunc));
    check_val({tag, "_used"}, 256'(fifo_used), 256'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_valid"}, 256'(out_valid), 256'd0);
    check_val({tag, "_data"}, 256'(out_data), 256'd0);
    check_val({tag, "_cnt"}, {cnt_pkt_in, cnt_pkt_out, cnt_drop, cnt_trunc}, 256'd0);
    check_val({tag, "_used"}, 256'(fifo_used), 256'd0);
  endtask

  // Sink ready pattern.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        2: out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      cyc++;
    end
  end

  // Output monitor: scoreboard and hold-stability checks.
  initial begin
    logic          hold;
    logic [OW-1:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (out_valid) valid_cycles++;
        if (hold) begin
          check_val("hold_valid", 256'(out_valid), 256'd1);
          check_val("hold_data", 256'(out_data), 256'(held));
        end
        if (out_valid && out_ready) begin
          rx_log.push_back(out_data);
          check_val("sb_word_avail", 256'(exp_q.size() != 0), 256'd1);
          if (exp_q.size() != 0) check_val("sb_word", 256'(out_data), 256'(exp_q.pop_front()));
        end
        hold = out_valid && !out_ready;
        held = out_data;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] w;
    int n_fit;

    @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 64-byte sequential frame
    rx_log.delete();
    make_seq(64); model_frame(); drive_frame(3);
    wait_drain("f64", 200);
    check_val("f64_words", 256'(rx_log.size()), 256'd4);
    w = {2'b01, 4'hf, 128'h000102030405060708090a0b0c0d0e0f};
    check_val("f64_word0", 256'(rx_log[0]), 256'(w));
    w = rx_log[rx_log.size() - 1];
    check_val("f64_last_tag_vb", 256'(w[OW-1 -: 6]), 256'h2f);
    check_counters("f64");

    // 37-byte frame, then a 16-byte runt
    rx_log.delete();
    make_seq(37); model_frame(); drive_frame(2);
    wait_drain("f37", 200);
    check_val("f37_words", 256'(rx_log.size()), 256'd3);
    w = {2'b10, 4'h4, 40'h2021222324, 88'h0};
    check_val("f37_last", 256'(rx_log[2]), 256'(w));
    valid_cycles = 0;
    make_seq(16); model_frame(); drive_frame(2);
    repeat (10) @(posedge clk);
    check_val("runt_valid_cycles", 256'(valid_cycles), 256'd0);
    check_counters("runt");

    // Oversized frame is truncated, next frame intact
    rx_log.delete();
    make_seq(3000); model_frame(); drive_frame(1);
    wait_drain("trunc", 500);
    check_val("trunc_words", 256'(rx_log.size()), 256'd131);
    w = rx_log[rx_log.size() - 1];
    check_val("trunc_last_tag_vb", 256'(w[OW-1 -: 6]), 256'h2f);
    make_seq(64); model_frame(); drive_frame(1);
    wait_drain("after_trunc", 200);
    check_counters("trunc");

    // Sink stalled: FIFO fills with whole frames, the rest are dropped
    ready_mode = 1;
    n_fit = FIFO_DEPTH / ((2000 + BPW - 1) / BPW);
    for (int f = 0; f < 8; f++) begin
      make_rand(2000);
      if (f < n_fit) model_frame();
      else m_drop++;
      drive_frame(1);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("ovf_used", 256'(fifo_used), 256'(n_fit * ((2000 + BPW - 1) / BPW)));
    check_val("ovf_valid", 256'(out_valid), 256'd1);
    check_val("ovf_drop", 256'(cnt_drop), 256'(m_drop));
    ready_mode = 0;
    wait_drain("ovf", 1000);
    check_counters("ovf");

    // Random frames against a throttled sink
    for (int f = 0; f < 24; f++) begin
      ready_mode = (f < 12) ? 2 : 3;
      if ($urandom_range(0, 7) == 0) make_rand($urandom_range(2090, 2200));
      else make_rand($urandom_range(1, 300));
      model_frame();
      drive_frame($urandom_range(1, 3));
    end
    ready_mode = 0;
    wait_drain("rand", 3000);
    check_counters("rand");

    // Reset in the middle of a frame
    make_rand(100);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      gmii_dv = 1'b1;
      gmii_data = frm[i];
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    gmii_dv = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_pkt_in = 0; m_drop = 0; m_trunc = 0;
    exp_q.delete();
    make_rand(80); model_frame(); drive_frame(2);
    wait_drain("postrst", 200);
    check_counters("postrst");

`ifdef GMII_PKT_ER_DROP_EN
    // Errored byte mid-frame and on the first byte
    valid_cycles = 0;
    make_rand(60);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      gmii_dv = 1'b1;
      gmii_data = frm[i];
      gmii_er = (i == 29);
    end
    @(posedge clk); #1;
    gmii_dv = 1'b0;
    gmii_er = 1'b0;
    m_drop++;
    @(posedge clk); #1;
    gmii_dv = 1'b1;
    gmii_er = 1'b1;
    @(posedge clk); #1;
    gmii_er = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    gmii_dv = 1'b0;
    m_drop++;
    repeat (10) @(posedge clk);
    check_val("er_valid_cycles", 256'(valid_cycles), 256'd0);
    check_counters("er");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
